// File: rtl/rr_mux_arbiter.sv
// Round-robin scheduler for the shared 8:1 mux. It picks one requester with rotating
// priority, drives the mux select, and holds the grant for at most MAX_HOLD cycles.
module rr_mux_arbiter #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [0:7] req,
   output logic [2:0] sel,
   output logic [0:7] grant,
   output logic       busy,
   output logic       timeout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

   logic [1:0]       state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [0:7]       grant_q, grant_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [2:0]       ptr_q, ptr_d;
   logic             timeout_q, timeout_d;

   logic             win_found;
   logic [2:0]       win_idx;
   logic [2:0]       scan_idx;

   // Search starts just past the last releaser; k = 8 wraps back onto ptr itself.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      scan_idx  = ptr_q;
      for (int k = 1; k <= 8; k++) begin
         scan_idx = ptr_q + k[2:0];
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
      state_d    = state_q;
      sel_d      = sel_q;
      grant_d    = grant_q;
      hold_cnt_d = hold_cnt_q;
      ptr_d      = ptr_q;
      timeout_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               sel_d      = win_idx;
               grant_d    = 8'b1000_0000 >> win_idx;
               hold_cnt_d = CNT_W'(1);
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!req[sel_q]) begin
               grant_d = '0;
               ptr_d   = sel_q;
               state_d = ST_GAP;
            end else if (hold_cnt_q == HOLD_LIMIT) begin
               grant_d   = '0;
               ptr_d     = sel_q;
               timeout_d = 1'b1;
               state_d   = ST_GAP;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sel_q      <= 3'd0;
         grant_q    <= '0;
         hold_cnt_q <= '0;
         ptr_q      <= 3'd7;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         grant_q    <= grant_d;
         hold_cnt_q <= hold_cnt_d;
         ptr_q      <= ptr_d;
         timeout_q  <= timeout_d;
      end
   end

   assign sel     = sel_q;
   assign grant   = grant_q;
   assign busy    = |grant_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: three instances (MAX_HOLD 4, 1, 16) share clock and
// reset; expected grants, selects and timeout pulses are hand-derived cycle patterns.
module tb_rr_mux_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [0:7] req4, req1, req16;
   logic [2:0] sel4, sel1, sel16;
   logic [0:7] grant4, grant1, grant16;
   logic       busy4, busy1, busy16;
   logic       timeout4, timeout1, timeout16;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
      .clk(clk), .reset(reset), .req(req4), .sel(sel4),
      .grant(grant4), .busy(busy4), .timeout(timeout4));

   rr_mux_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .req(req1), .sel(sel1),
      .grant(grant1), .busy(busy1), .timeout(timeout1));

   rr_mux_arbiter #(.MAX_HOLD(16), .CNT_W(8)) dut16 (
      .clk(clk), .reset(reset), .req(req16), .sel(sel16),
      .grant(grant16), .busy(busy16), .timeout(timeout16));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [0:7] onehot(input int w);
      logic [0:7] v;
      v    = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      req4  = '0;
      req1  = '0;
      req16 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Structural invariants on every instance, every cycle.
   always @(negedge clk) begin
      check("inv4_onehot",   32'($onehot0(grant4)),  32'd1);
      check("inv4_selbusy",  32'(grant4[sel4]),      32'(busy4));
      check("inv1_onehot",   32'($onehot0(grant1)),  32'd1);
      check("inv1_selbusy",  32'(grant1[sel1]),      32'(busy1));
      check("inv16_onehot",  32'($onehot0(grant16)), 32'd1);
      check("inv16_selbusy", 32'(grant16[sel16]),    32'(busy16));
   end

   logic [0:7] exp_g;
   int         ph, w;
   int         run_len;
   int         waiting [8];
   logic       prev_busy;
   int         winners [3];

   initial begin
      reset = 1'b1;
      req4  = '0;
      req1  = '0;
      req16 = '0;
      @(negedge clk);
      check("rst_sel",     32'(sel4),     32'd0);
      check("rst_grant",   32'(grant4),   32'd0);
      check("rst_busy",    32'(busy4),    32'd0);
      check("rst_timeout", 32'(timeout4), 32'd0);

      // Single requester 0 held for 3 cycles.
      do_reset();
      req4 = 8'b1000_0000;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         exp_g = (c <= 3) ? onehot(0) : 8'b0;
         check($sformatf("t1_grant c%0d", c),   32'(grant4),   32'(exp_g));
         check($sformatf("t1_sel c%0d", c),     32'(sel4),     32'd0);
         check($sformatf("t1_timeout c%0d", c), 32'(timeout4), 32'd0);
         if (c == 3) req4 = '0;
      end

      // All requesting, MAX_HOLD=4: 4 grant cycles, GAP with timeout, IDLE, next winner.
      do_reset();
      req4 = 8'b1111_1111;
      for (int c = 1; c <= 54; c++) begin
         @(negedge clk);
         ph    = (c - 1) % 6;
         w     = ((c - 1) / 6) % 8;
         exp_g = (ph < 4) ? onehot(w) : 8'b0;
         check($sformatf("t2_grant c%0d", c),   32'(grant4),   32'(exp_g));
         check($sformatf("t2_sel c%0d", c),     32'(sel4),     32'(w));
         check($sformatf("t2_timeout c%0d", c), 32'(timeout4), 32'(ph == 4));
      end
      req4 = '0;

      // Requesters 2 and 5 alternate.
      do_reset();
      req4    = 8'b0010_0100;
      winners = '{2, 5, 2};
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         ph    = (c - 1) % 6;
         w     = winners[(c - 1) / 6];
         exp_g = (ph < 4) ? onehot(w) : 8'b0;
         check($sformatf("t3_grant c%0d", c), 32'(grant4), 32'(exp_g));
         check($sformatf("t3_sel c%0d", c),   32'(sel4),   32'(w));
      end
      req4 = '0;

      // Release coinciding with hold limit is a normal release; late request 0 waits for IDLE.
      do_reset();
      req4 = 8'b0100_0000;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         exp_g = (c <= 4) ? onehot(1) : (c == 7) ? onehot(0) : 8'b0;
         check($sformatf("t4_grant c%0d", c),   32'(grant4),   32'(exp_g));
         check($sformatf("t4_sel c%0d", c),     32'(sel4),     (c == 7) ? 32'd0 : 32'd1);
         check($sformatf("t4_timeout c%0d", c), 32'(timeout4), 32'd0);
         if (c == 2) req4 = 8'b1100_0000;
         if (c == 4) req4 = 8'b1000_0000;
      end
      req4 = '0;

      // MAX_HOLD=1 with requester 3: one cycle on, GAP with timeout, IDLE.
      do_reset();
      req1 = 8'b0001_0000;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         ph    = (c - 1) % 3;
         exp_g = (ph == 0) ? onehot(3) : 8'b0;
         check($sformatf("t5_grant c%0d", c),   32'(grant1),   32'(exp_g));
         check($sformatf("t5_sel c%0d", c),     32'(sel1),     32'd3);
         check($sformatf("t5_timeout c%0d", c), 32'(timeout1), 32'(ph == 1));
      end
      req1 = '0;

      // Asynchronous reset in the middle of a grant to requester 6.
      do_reset();
      req4 = 8'b0000_0010;
      @(negedge clk);
      check("t6_grant_pre", 32'(grant4), 32'(onehot(6)));
      @(negedge clk);
      check("t6_sel_pre",   32'(sel4),   32'd6);
      #2 reset = 1'b1;
      #1;
      check("t6_grant_rst",   32'(grant4),   32'd0);
      check("t6_sel_rst",     32'(sel4),     32'd0);
      check("t6_busy_rst",    32'(busy4),    32'd0);
      check("t6_timeout_rst", 32'(timeout4), 32'd0);
      req4 = 8'b0000_0011;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t6_grant_post", 32'(grant4), 32'(onehot(6)));
      check("t6_sel_post",   32'(sel4),   32'd6);
      req4 = '0;

      // Slowly varying random requests on the MAX_HOLD=16 instance.
      do_reset();
      run_len   = 0;
      prev_busy = 1'b0;
      for (int i = 0; i < 8; i++) waiting[i] = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         run_len = busy16 ? run_len + 1 : 0;
         if (run_len > 16) check($sformatf("r_hold c%0d", c), 32'(run_len), 32'd16);
         if (busy16 && !prev_busy) begin
            check($sformatf("r_winner_req c%0d", c), 32'(req16[sel16]), 32'd1);
            for (int i = 0; i < 8; i++) begin
               if (i == int'(sel16)) waiting[i] = 0;
               else if (req16[i]) begin
                  waiting[i]++;
                  if (waiting[i] > 7)
                     check($sformatf("r_starve%0d c%0d", i, c), 32'(waiting[i]), 32'd7);
               end
            end
         end
         prev_busy = busy16;
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               req16[i] = ~req16[i];
               if (!req16[i]) waiting[i] = 0;
            end
         end
      end
      req16 = '0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
